// File: rtl/exe_iter_if.sv
// Handshake bundle for exe_iter: upstream issue port and downstream result port.
// slave = execution unit side, master = the agent feeding and draining it.
interface exe_iter_if #(
    parameter int WIDTH   = 16,
    parameter int RADDR_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_instr;
    logic [WIDTH-1:0]   in_pc;
    logic [WIDTH-1:0]   in_op1;
    logic [WIDTH-1:0]   in_op2;
    logic [WIDTH-1:0]   in_mem_data;
    logic [7:0]         in_alu_opcode;
    logic [RADDR_W-1:0] in_wreg_addr;
    logic [1:0]         in_rwe;
    logic               in_branch;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_instr;
    logic [WIDTH-1:0]   out_pc;
    logic [WIDTH-1:0]   out_result;
    logic [WIDTH-1:0]   out_mem_data;
    logic [RADDR_W-1:0] out_wreg_addr;
    logic [1:0]         out_rwe;
    logic               out_branch;

    modport slave (
        input  in_valid, in_instr, in_pc, in_op1, in_op2, in_mem_data,
               in_alu_opcode, in_wreg_addr, in_rwe, in_branch, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_result,
               out_mem_data, out_wreg_addr, out_rwe, out_branch
    );

    modport master (
        output in_valid, in_instr, in_pc, in_op1, in_op2, in_mem_data,
               in_alu_opcode, in_wreg_addr, in_rwe, in_branch, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_result,
               out_mem_data, out_wreg_addr, out_rwe, out_branch
    );
endinterface

// File: rtl/exe_iter.sv
// Execute stage: single-cycle ALU plus iterative shift-add multiplier and
// restoring divider. Define EXE_ITER_DIV_EN to build DIV/REM; otherwise they decode as unknown.
//
// state | meaning
// IDLE  | empty, ready for a new op
// BUSY  | iterating MUL/DIV/REM, WIDTH cycles
// DONE  | result valid, held until out_ready
module exe_iter #(
    parameter int WIDTH   = 16,
    parameter int RADDR_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    exe_iter_if.slave io
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef EXE_ITER_DIV_EN
    localparam int AW    = WIDTH + 1;
`else
    localparam int AW    = WIDTH;
`endif

    localparam logic [7:0] ALU_OPCODE_NOP = 8'h00;
    localparam logic [7:0] ALU_OPCODE_ADD = 8'h01;
    localparam logic [7:0] ALU_OPCODE_SUB = 8'h02;
    localparam logic [7:0] ALU_OPCODE_AND = 8'h03;
    localparam logic [7:0] ALU_OPCODE_OR  = 8'h04;
    localparam logic [7:0] ALU_OPCODE_CMP = 8'h05;
    localparam logic [7:0] ALU_OPCODE_SLL = 8'h06;
    localparam logic [7:0] ALU_OPCODE_SRL = 8'h07;
    localparam logic [7:0] ALU_OPCODE_SRA = 8'h08;
    localparam logic [7:0] ALU_OPCODE_MUL = 8'h09;
    localparam logic [7:0] ALU_OPCODE_DIV = 8'h0A;
    localparam logic [7:0] ALU_OPCODE_REM = 8'h0B;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   instr_q, instr_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   mem_q, mem_d;
    logic [RADDR_W-1:0] wreg_q, wreg_d;
    logic [1:0]         rwe_q, rwe_d;
    logic               branch_q, branch_d;

    logic               rdy;
    logic               accept;
    logic               start_iter;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   acc_mul;
`ifdef EXE_ITER_DIV_EN
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH:0]     div_rem;
`endif

    always_comb begin
        shamt = io.in_op2[SH_W-1:0];
        case (io.in_alu_opcode)
            ALU_OPCODE_NOP: alu_res = '0;
            ALU_OPCODE_ADD: alu_res = io.in_op1 + io.in_op2;
            ALU_OPCODE_SUB: alu_res = io.in_op1 - io.in_op2;
            ALU_OPCODE_AND: alu_res = io.in_op1 & io.in_op2;
            ALU_OPCODE_OR:  alu_res = io.in_op1 | io.in_op2;
            ALU_OPCODE_CMP: alu_res = (io.in_op1 == io.in_op2) ? '0 : WIDTH'(1);
            ALU_OPCODE_SLL: alu_res = io.in_op1 << shamt;
            ALU_OPCODE_SRL: alu_res = io.in_op1 >> shamt;
            ALU_OPCODE_SRA: alu_res = $unsigned($signed(io.in_op1) >>> shamt);
            default:        alu_res = WIDTH'(8'hFE);
        endcase
    end

    always_comb begin
        start_iter = (io.in_alu_opcode == ALU_OPCODE_MUL);
`ifdef EXE_ITER_DIV_EN
        if ((io.in_alu_opcode == ALU_OPCODE_DIV) || (io.in_alu_opcode == ALU_OPCODE_REM))
            start_iter = 1'b1;
`endif
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        mem_d    = mem_q;
        wreg_d   = wreg_q;
        rwe_d    = rwe_q;
        branch_d = branch_q;

        rdy    = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && io.out_ready));
        accept = io.in_valid && rdy;

        acc_mul = acc_q[WIDTH-1:0] + (y_q[0] ? x_q : '0);
`ifdef EXE_ITER_DIV_EN
        div_sh  = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, y_q});
        div_rem = div_ge ? (div_sh - {1'b0, y_q}) : div_sh;
`endif

        case (state_q)
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (kind_q == K_MUL) begin
                    acc_d = AW'(acc_mul);
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                    if (cnt_q == CNT_W'(1))
                        result_d = acc_mul;
                end
`ifdef EXE_ITER_DIV_EN
                else begin
                    // Quotient bits shift into x as the dividend bits shift out.
                    acc_d = div_rem;
                    x_d   = {x_q[WIDTH-2:0], div_ge};
                    if (cnt_q == CNT_W'(1))
                        result_d = (kind_q == K_DIV) ? {x_q[WIDTH-2:0], div_ge}
                                                     : div_rem[WIDTH-1:0];
                end
`endif
                if (cnt_q == CNT_W'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (io.out_ready)
                    state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            instr_d  = io.in_instr;
            pc_d     = io.in_pc;
            mem_d    = io.in_mem_data;
            wreg_d   = io.in_wreg_addr;
            rwe_d    = io.in_rwe;
            branch_d = io.in_branch;
            if (start_iter) begin
                state_d = S_BUSY;
                cnt_d   = CNT_W'(WIDTH);
                acc_d   = '0;
                x_d     = io.in_op1;
                y_d     = io.in_op2;
                kind_d  = K_MUL;
`ifdef EXE_ITER_DIV_EN
                if (io.in_alu_opcode == ALU_OPCODE_DIV) kind_d = K_DIV;
                if (io.in_alu_opcode == ALU_OPCODE_REM) kind_d = K_REM;
`endif
            end else begin
                state_d  = S_DONE;
                result_d = alu_res;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kind_q   <= K_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            instr_q  <= '0;
            pc_q     <= '0;
            mem_q    <= '0;
            wreg_q   <= '0;
            rwe_q    <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            mem_q    <= mem_d;
            wreg_q   <= wreg_d;
            rwe_q    <= rwe_d;
            branch_q <= branch_d;
        end
    end

    assign io.in_ready      = rdy;
    assign io.out_valid     = (state_q == S_DONE);
    assign io.out_instr     = instr_q;
    assign io.out_pc        = pc_q;
    assign io.out_result    = result_q;
    assign io.out_mem_data  = mem_q;
    assign io.out_wreg_addr = wreg_q;
    assign io.out_rwe       = rwe_q;
    assign io.out_branch    = branch_q;
endmodule

// File: doc/exe_iter.md
EXE_ITER -- requirements
Module: exe_iter

Interface
REQ-001 Parameter WIDTH, default 16, operand/result/PC/instruction width; SHALL be an even value from 8 to 32.
REQ-002 Parameter RADDR_W, default 4, write-register address width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 flush  input  1  synchronous abort of any in-flight or held operation.
REQ-006 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-007 in_instr, in_pc, in_op1, in_op2, in_mem_data  input  WIDTH each  instruction, PC, operands, store data.
REQ-008 in_alu_opcode  input  8  ALU_OPCODE_* encodings from defines.v, plus new ALU_OPCODE_MUL, ALU_OPCODE_DIV and ALU_OPCODE_REM defined there.
REQ-009 in_wreg_addr, in_rwe, in_branch  input  RADDR_W / 2 / 1  sideband fields.
REQ-010 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-011 out_instr, out_pc, out_result, out_mem_data  output  WIDTH each; out_wreg_addr, out_rwe, out_branch  output  RADDR_W / 2 / 1.

Function
REQ-012 A transfer occurs on a cycle with in_valid && in_ready; all inputs SHALL be captured into internal registers on that edge.
REQ-013 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE) || (state==DONE && out_ready); out_valid = (state==DONE).
REQ-014 Single-cycle ops (NOP, ADD, SUB, AND, OR, CMP, SLL, SRA, SRL, unknown): accept -> DONE on the next edge, latency 1.
REQ-015 NOP -> 0; ADD/SUB -> modulo 2^WIDTH; AND/OR bitwise; CMP -> 0 if op1==op2, else 1.
REQ-016 SLL/SRL/SRA shift op1 by op2[log2(WIDTH)-1:0]; SRA fills with op1[WIDTH-1].
REQ-017 Unknown opcode -> result 16'hFE, zero-extended to WIDTH.
REQ-018 MUL: unsigned radix-2 shift-add; accept -> BUSY for exactly WIDTH cycles -> DONE; latency WIDTH+1; result = low WIDTH bits of the product.
REQ-019 DIV/REM: unsigned restoring division, same timing as MUL; DIV -> quotient, REM -> remainder.
REQ-020 Divide by zero -> quotient all ones, remainder = op1; timing unchanged.
REQ-021 In DONE all outputs SHALL stay stable while out_ready=0.
REQ-022 DONE with out_ready=1 and in_valid=1 SHALL accept the new op on the same edge (back-to-back, no bubble); DONE with out_ready=1 and in_valid=0 -> IDLE.
REQ-023 Sideband outputs SHALL equal the values captured at accept, for the full life of the op.
REQ-024 flush=1 SHALL force IDLE on the next edge from any state, discard the in-flight/held op, and deassert in_ready during that cycle; flush has priority over accept and over completion.
REQ-025 Iteration counter width = clog2(WIDTH)+1; the counter SHALL NOT wrap inside an operation.

Reset
REQ-026 While rst=1: state IDLE, out_valid=0, and all output registers and the iteration counter 0; in_ready=1 once rst deasserts.
REQ-027 rst asserted mid-BUSY or in DONE SHALL abandon the op; no out_valid pulse follows.

Configuration
REQ-028 Macro EXE_ITER_DIV_EN: defined -> DIV/REM implemented per REQ-019/020; undefined -> no divider logic, and DIV/REM behave as unknown opcodes (0xFE, latency 1).

Verification
REQ-029 ADD 0x7FFF+0x0001, out_ready=1 -> out_valid one cycle after accept, result 0x8000.
REQ-030 SRA 0x8000 by 0x0013 -> shift 3, result 0xF000; SRL gives 0x1000.
REQ-031 MUL 0x0123*0x0045 -> out_valid exactly 17 cycles after accept, result 0x4E6F; in_ready=0 for cycles 1-16.
REQ-032 DIV 100/7 -> 0x000E; REM -> 0x0002; DIV 5/0 -> 0xFFFF; REM 5/0 -> 0x0005 (EXE_ITER_DIV_EN defined); undefined -> 0x00FE after 1 cycle.
REQ-033 Result held with out_ready=0 for 5 cycles -> outputs stable; then out_ready=1 with in_valid=1 -> new op accepted the same edge.
REQ-034 flush at cycle 8 of a MUL -> IDLE next edge, no out_valid; rst mid-DIV -> all outputs 0, in_ready=1 after release.
